// File: rtl/ddr3_wb_arbiter.sv
// ddr3_wb_arbiter: two-master pipelined Wishbone arbiter in front of the DDR3
// controller port. Master 0 is the CPU data path and master 1 is the
// framebuffer fetch engine.
// The grant is held for a whole bus cycle. Accepted-but-unanswered requests
// are counted so that every response goes back to the master that issued it.
// The port is only handed to the other master once the count has drained to 0.
// Build option: define WB_ARB_ROUND_ROBIN_EN to make simultaneous requests
// alternate between the masters. Without it, master 0 has fixed priority.
// Handshake: a request transfers on a cycle where s_stb_o=1 and s_stall_i=0.
// Each response (ack, err or rty) retires exactly one outstanding request.
module ddr3_wb_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [ADDRESS_WIDTH-1:0]  m0_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic                      m0_rty_o,
    output logic                      m0_stall_o,
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [ADDRESS_WIDTH-1:0]  m1_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic                      m1_rty_o,
    output logic                      m1_stall_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDRESS_WIDTH-1:0]  s_addr_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic [DATA_WIDTH-1:0]     s_wdata_o,
    input  logic [DATA_WIDTH-1:0]     s_rdata_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    input  logic                      s_stall_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic own_cyc, own_stb, resp, full, live_resp, accept;

    // State, grant owner, last owner and outstanding count registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, arbitration, request/response steering and count update
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;

        own_cyc    = owner_q ? m1_cyc_i : m0_cyc_i;
        own_stb    = owner_q ? m1_stb_i : m0_stb_i;
        resp       = s_ack_i | s_err_i | s_rty_i;
        full       = (cnt_q == MAX_CNT);
        // A response with nothing outstanding is a protocol error: it is dropped.
        live_resp  = resp & (cnt_q != '0);

        s_we_o     = owner_q ? m1_we_i    : m0_we_i;
        s_addr_o   = owner_q ? m1_addr_i  : m0_addr_i;
        s_sel_o    = owner_q ? m1_sel_i   : m0_sel_i;
        s_wdata_o  = owner_q ? m1_wdata_i : m0_wdata_i;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;

        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;
        m0_rdata_o = '0;
        m1_rdata_o = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i | m1_cyc_i) begin
                    state_d = GRANT;
`ifdef WB_ARB_ROUND_ROBIN_EN
                    if (m0_cyc_i & m1_cyc_i) owner_d = ~last_q;
                    else                     owner_d = m1_cyc_i;
`else
                    owner_d = ~m0_cyc_i;
`endif
                end
            end
            GRANT: begin
                s_cyc_o = own_cyc;
                s_stb_o = own_cyc & own_stb & ~full;
                if (owner_q) begin
                    m1_stall_o = s_stall_i | full;
                    m1_ack_o   = s_ack_i & live_resp;
                    m1_err_o   = s_err_i & live_resp;
                    m1_rty_o   = s_rty_i & live_resp;
                    m1_rdata_o = s_rdata_i;
                end else begin
                    m0_stall_o = s_stall_i | full;
                    m0_ack_o   = s_ack_i & live_resp;
                    m0_err_o   = s_err_i & live_resp;
                    m0_rty_o   = s_rty_i & live_resp;
                    m0_rdata_o = s_rdata_i;
                end
                if (!own_cyc) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_cyc_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        accept = s_stb_o & ~s_stall_i;

        if (state_q != IDLE) begin
            case ({accept, live_resp})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        if (state_q == DRAIN && cnt_d == '0) begin
            state_d = IDLE;
            last_d  = owner_q;
        end
    end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Directed bench for ddr3_wb_arbiter. It covers reset, simultaneous
// arbitration, a pipelined single-master read burst, the outstanding cap,
// drain-before-handover and reset in the middle of a burst.
module tb_ddr3_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_addr_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [DW-1:0]   m0_wdata_i, m0_rdata_o;
    logic            m0_ack_o, m0_err_o, m0_rty_o, m0_stall_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_addr_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [DW-1:0]   m1_wdata_i, m1_rdata_o;
    logic            m1_ack_o, m1_err_o, m1_rty_o, m1_stall_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW/8-1:0] s_sel_o;
    logic [DW-1:0]   s_wdata_o, s_rdata_i;
    logic            s_ack_i, s_err_i, s_rty_i, s_stall_i;

    int total = 0;
    int bad   = 0;
    int acks, accepts;
    logic exp_owner;

    ddr3_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i), .m0_wdata_i(m0_wdata_i),
        .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_rty_o(m0_rty_o), .m0_stall_o(m0_stall_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_rty_o(m1_rty_o), .m1_stall_o(m1_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_sel_o(s_sel_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_rty_i(s_rty_i), .s_stall_i(s_stall_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Move to just after the next active edge; inputs are driven here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_sel_i = '1; m0_wdata_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_sel_i = '1; m1_wdata_i = '0;
        s_rdata_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_stall_i = 0;

        // ---------------- reset values
        step(); step();
        reset_i = 1'b0;
        #1;
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_s_stb", 64'(s_stb_o), 64'd0);
        chk("rst_m0_stall", 64'(m0_stall_o), 64'd1);
        chk("rst_m1_stall", 64'(m1_stall_o), 64'd1);
        chk("rst_acks", 64'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 64'd0);
        chk("rst_rdata", 64'({m0_rdata_o, m1_rdata_o}), 64'd0);
        chk("rst_cnt", 64'(dut.cnt_q), 64'd0);

        // ---------------- simultaneous requests, three rounds
        for (int r = 0; r < 3; r++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            exp_owner = (r == 1);
`else
            exp_owner = 1'b0;
`endif
            m0_cyc_i = 1; m1_cyc_i = 1; m0_addr_i = 32'h0000_0A00; m1_addr_i = 32'h0000_0B00;
            #1;
            chk("arb_idle_m0_stall", 64'(m0_stall_o), 64'd1);
            chk("arb_idle_s_cyc", 64'(s_cyc_o), 64'd0);
            step(); #1;
            chk("arb_m0_stall", 64'(m0_stall_o), 64'(exp_owner));
            chk("arb_m1_stall", 64'(m1_stall_o), 64'(!exp_owner));
            chk("arb_s_cyc", 64'(s_cyc_o), 64'd1);
            chk("arb_s_addr", 64'(s_addr_o), exp_owner ? 64'h0B00 : 64'h0A00);
            step();
            m0_cyc_i = 0; m1_cyc_i = 0;
            #1;
            chk("arb_drop_s_cyc", 64'(s_cyc_o), 64'd0);
            step();
        end

        // ---------------- single master m1: 4 pipelined reads
        m1_cyc_i = 1;
        step();
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            m1_stb_i  = (i < 4);
            m1_addr_i = 32'h100 + 32'(4 * i);
            s_ack_i   = (i >= 1 && i <= 4);
            s_rdata_i = 32'hA0 + 32'(i - 1);
            #1;
            chk("m1_s_stb", 64'(s_stb_o), 64'(i < 4));
            if (i < 4) chk("m1_s_addr", 64'(s_addr_o), 64'h100 + 64'(4 * i));
            chk("m1_ack", 64'(m1_ack_o), 64'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) begin
                chk("m1_rdata", 64'(m1_rdata_o), 64'hA0 + 64'(i - 1));
                if (m1_ack_o) acks++;
            end
            chk("m1_m0_stall", 64'(m0_stall_o), 64'd1);
            chk("m1_m0_ack", 64'(m0_ack_o), 64'd0);
            step();
        end
        chk("m1_ack_count", 64'(acks), 64'd4);
        m1_stb_i = 0; s_ack_i = 0; s_rdata_i = '0; m1_cyc_i = 0;
        step(); step();

        // ---------------- outstanding cap on m0
        m0_cyc_i = 1;
        step();
        m0_stb_i = 1;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cap_s_stb", 64'(s_stb_o), 64'(i < 4));
            chk("cap_m0_stall", 64'(m0_stall_o), 64'(i >= 4));
            if (s_stb_o && !s_stall_i) accepts++;
            step();
        end
        chk("cap_accepts", 64'(accepts), 64'd4);
        s_ack_i = 1;
        #1;
        chk("cap_full_ack_stb", 64'(s_stb_o), 64'd0);
        chk("cap_full_ack_fwd", 64'(m0_ack_o), 64'd1);
        step();
        s_ack_i = 0;
        #1;
        chk("cap_one_more_stb", 64'(s_stb_o), 64'd1);
        step(); #1;
        chk("cap_full_again", 64'(s_stb_o), 64'd0);
        chk("cap_cnt4", 64'(dut.cnt_q), 64'd4);

        // ---------------- drain: bring count to 2, then m0 drops cyc with m1 waiting
        m0_stb_i = 0;
        step();
        s_ack_i = 1;
        step(); step();
        s_ack_i = 0;
        #1;
        chk("drain_cnt2", 64'(dut.cnt_q), 64'd2);
        m0_cyc_i = 0; m1_cyc_i = 1;
        step();
        s_ack_i = 1;
        #1;
        chk("drain_s_cyc", 64'(s_cyc_o), 64'd1);
        chk("drain_s_stb", 64'(s_stb_o), 64'd0);
        chk("drain_m0_ack", 64'(m0_ack_o), 64'd0);
        chk("drain_m1_ack", 64'(m1_ack_o), 64'd0);
        chk("drain_m1_stall", 64'(m1_stall_o), 64'd1);
        step(); #1;
        chk("drain2_m0_ack", 64'(m0_ack_o), 64'd0);
        chk("drain2_m1_ack", 64'(m1_ack_o), 64'd0);
        chk("drain2_s_cyc", 64'(s_cyc_o), 64'd1);
        step();
        s_ack_i = 0;
        #1;
        chk("drain_idle_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("drain_idle_m1_stall", 64'(m1_stall_o), 64'd1);
        step(); #1;
        chk("handover_m1_stall", 64'(m1_stall_o), 64'd0);
        chk("handover_s_cyc", 64'(s_cyc_o), 64'd1);

        // ---------------- reset mid-burst: m1 gets 3 requests accepted
        m1_stb_i = 1;
        step(); step(); step();
        m1_stb_i = 0;
        #1;
        chk("midrst_cnt3", 64'(dut.cnt_q), 64'd3);
        reset_i = 1;
        step();
        reset_i = 0;
        s_ack_i = 1;
        #1;
        chk("midrst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("midrst_cnt0", 64'(dut.cnt_q), 64'd0);
        chk("midrst_late_ack", 64'({m0_ack_o, m1_ack_o}), 64'd0);
        step(); #1;
        chk("midrst_grant_ack", 64'({m0_ack_o, m1_ack_o}), 64'd0);
        step(); #1;
        chk("midrst_no_underflow", 64'(dut.cnt_q), 64'd0);
        s_ack_i = 0; m1_cyc_i = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
